// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared source tags and sizing constants for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {SRC_NONE, SRC_FETCH, SRC_LOAD, SRC_STORE} src_t;
  localparam int MEM_LATENCY_MAX = 4;
  localparam int STARVE_CNT_W = 4;
endpackage

// File: rtl/mem_arb_tag_pipe.sv
// mem_arb_tag_pipe: DEPTH-stage shift register of access source tags with async clear
module mem_arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  src_t src_i,
  output src_t src_o
);
  src_t stage_q [DEPTH];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= SRC_NONE;
    end else begin
      stage_q[0] <= src_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  assign src_o = stage_q[DEPTH-1];
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch, load and store with fetch anti-starvation
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              fetch_req_valid,
  input  logic [ADDR_W-1:0] fetch_req_addr,
  output logic              fetch_req_ready,
  output logic              fetch_resp_valid,
  output logic [DATA_W-1:0] fetch_resp_data,
  output logic              fetch_resp_exception,
  input  logic              load_req_valid,
  input  logic [ADDR_W-1:0] load_req_addr,
  output logic              load_req_ready,
  output logic              load_resp_valid,
  output logic [DATA_W-1:0] load_resp_data,
  output logic              load_resp_exception,
  input  logic              store_req_valid,
  input  logic [ADDR_W-1:0] store_req_addr,
  input  logic [DATA_W-1:0] store_req_data,
  output logic              store_req_ready,
  output logic              store_resp_valid,
  output logic              store_resp_exception,
  output logic              mem_enable,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_exception
);
  if (MEM_LATENCY < 1 || MEM_LATENCY > MEM_LATENCY_MAX) begin : g_bad_latency
    $error("MEM_LATENCY out of range");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
    $error("STARVE_LIMIT out of range");
  end
  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);
  logic [STARVE_CNT_W-1:0] starve_q, starve_d;
  logic fetch_pri, gnt_f, gnt_l, gnt_s;
  src_t gnt_src, resp_src;
  always_comb begin
    fetch_pri = fetch_req_valid && starve_q == LIMIT;
    gnt_s     = !RESET && store_req_valid && !fetch_pri;
    gnt_l     = !RESET && load_req_valid && !store_req_valid && !fetch_pri;
    gnt_f     = !RESET && fetch_req_valid && (fetch_pri || (!store_req_valid && !load_req_valid));
    gnt_src   = gnt_s ? SRC_STORE : gnt_l ? SRC_LOAD : gnt_f ? SRC_FETCH : SRC_NONE;
    starve_d  = (!fetch_req_valid || gnt_f) ? '0 :
                (starve_q == LIMIT) ? starve_q : starve_q + STARVE_CNT_W'(1);
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) starve_q <= '0;
    else starve_q <= starve_d;
  mem_arb_tag_pipe #(.DEPTH(MEM_LATENCY)) u_tag_pipe (
    .clk  (CLK),
    .rst  (RESET),
    .src_i(gnt_src),
    .src_o(resp_src)
  );
  assign fetch_req_ready      = gnt_f;
  assign load_req_ready       = gnt_l;
  assign store_req_ready      = gnt_s;
  assign mem_enable           = gnt_s || gnt_l || gnt_f;
  assign mem_write            = gnt_s;
  assign mem_addr             = gnt_s ? store_req_addr : gnt_l ? load_req_addr : gnt_f ? fetch_req_addr : '0;
  assign mem_wdata            = gnt_s ? store_req_data : '0;
  assign fetch_resp_valid     = resp_src == SRC_FETCH;
  assign fetch_resp_data      = fetch_resp_valid ? mem_rdata : '0;
  assign fetch_resp_exception = fetch_resp_valid && mem_exception;
  assign load_resp_valid      = resp_src == SRC_LOAD;
  assign load_resp_data       = load_resp_valid ? mem_rdata : '0;
  assign load_resp_exception  = load_resp_valid && mem_exception;
  assign store_resp_valid     = resp_src == SRC_STORE;
  assign store_resp_exception = store_resp_valid && mem_exception;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized scoreboard bench with a spec-level grant/memory model
module tb_mem_port_arbiter;
  localparam int LAT = 3;
  localparam int SL  = 4;
  logic CLK = 0, RESET = 1;
  logic fetch_req_valid = 0, load_req_valid = 0, store_req_valid = 0;
  logic [31:0] fetch_req_addr = 0, load_req_addr = 0, store_req_addr = 0, store_req_data = 0;
  logic fetch_req_ready, load_req_ready, store_req_ready;
  logic fetch_resp_valid, load_resp_valid, store_resp_valid;
  logic fetch_resp_exception, load_resp_exception, store_resp_exception;
  logic [31:0] fetch_resp_data, load_resp_data;
  logic mem_enable, mem_write, mem_exception;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT), .STARVE_LIMIT(SL)) dut (
    .CLK(CLK), .RESET(RESET),
    .fetch_req_valid(fetch_req_valid), .fetch_req_addr(fetch_req_addr), .fetch_req_ready(fetch_req_ready),
    .fetch_resp_valid(fetch_resp_valid), .fetch_resp_data(fetch_resp_data), .fetch_resp_exception(fetch_resp_exception),
    .load_req_valid(load_req_valid), .load_req_addr(load_req_addr), .load_req_ready(load_req_ready),
    .load_resp_valid(load_resp_valid), .load_resp_data(load_resp_data), .load_resp_exception(load_resp_exception),
    .store_req_valid(store_req_valid), .store_req_addr(store_req_addr), .store_req_data(store_req_data),
    .store_req_ready(store_req_ready), .store_resp_valid(store_resp_valid), .store_resp_exception(store_resp_exception),
    .mem_enable(mem_enable), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_exception(mem_exception)
  );
  typedef struct { bit v; logic [31:0] a; logic [31:0] d; } req_t;
  typedef struct { int src; logic [31:0] data; bit exc; int due; } exp_t;
  req_t rq [3];
  exp_t sbq [$];
  int glog [$];
  logic [31:0] ram [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] pd [LAT] = '{default: '0};
  logic pe [LAT] = '{default: 1'b0};
  int cyc = 0, tests = 0, fails = 0, wait_cnt = 0;
  bit keep_load = 0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction
  function automatic bit faulty(input logic [31:0] a);
    return a[31:28] == 4'hF;
  endfunction
  function automatic logic [31:0] rnd_addr();
    return ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 : 32'h200 + 4 * $urandom_range(0, 7);
  endfunction
  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic check_zero(input string name);
    check(name, {fetch_req_ready, load_req_ready, store_req_ready, fetch_resp_valid, load_resp_valid,
                 store_resp_valid, fetch_resp_exception, load_resp_exception, store_resp_exception,
                 fetch_resp_data, load_resp_data, mem_enable, mem_write, mem_addr, mem_wdata}, '0);
  endtask
  // memory32 stand-in: writes commit at issue, reads return after LAT cycles
  always @(posedge CLK) begin
    logic [31:0] d;
    logic e;
    if (mem_enable) begin
      e = faulty(mem_addr);
      d = mem_write ? 32'h0 : (ram.exists(mem_addr) ? ram[mem_addr] : dflt(mem_addr));
      if (mem_write) ram[mem_addr] = mem_wdata;
    end else begin
      d = $urandom;
      e = 1'($urandom_range(0, 1));
    end
    for (int i = LAT - 1; i > 0; i--) begin
      pd[i] <= pd[i-1];
      pe[i] <= pe[i-1];
    end
    pd[0] <= d;
    pe[0] <= e;
  end
  assign mem_rdata = pd[LAT-1];
  assign mem_exception = pe[LAT-1];
  task automatic drive();
    fetch_req_valid = rq[0].v; fetch_req_addr = rq[0].a;
    load_req_valid  = rq[1].v; load_req_addr  = rq[1].a;
    store_req_valid = rq[2].v; store_req_addr = rq[2].a; store_req_data = rq[2].d;
  endtask
  task automatic step(input bit rnd);
    int g;
    bit fpend;
    logic [31:0] a;
    @(negedge CLK);
    if (rnd) begin
      if (!rq[0].v && $urandom_range(0, 99) < 70) rq[0] = '{1'b1, rnd_addr(), 32'h0};
      if (!rq[1].v && $urandom_range(0, 99) < 40) rq[1] = '{1'b1, rnd_addr(), 32'h0};
      if (!rq[2].v && $urandom_range(0, 99) < 30) rq[2] = '{1'b1, rnd_addr(), $urandom};
    end
    if (keep_load && !rq[1].v) rq[1] = '{1'b1, 32'h300, 32'h0};
    drive();
    #1;
    fpend = rq[0].v;
    g = (fpend && wait_cnt == SL) ? 1 : rq[2].v ? 3 : rq[1].v ? 2 : fpend ? 1 : 0;
    check("grant", {fetch_req_ready, load_req_ready, store_req_ready}, {g == 1, g == 2, g == 3});
    check("mem_ctl", {mem_enable, mem_write, mem_wdata}, {g != 0, g == 3, (g == 3) ? rq[2].d : 32'h0});
    if (g != 0) begin
      a = rq[g-1].a;
      check("mem_addr", mem_addr, a);
      sbq.push_back('{g, (g == 3) ? 32'h0 : (ref_mem.exists(a) ? ref_mem[a] : dflt(a)), faulty(a), cyc + LAT});
      if (g == 3) ref_mem[a] = rq[2].d;
      rq[g-1].v = 0;
      glog.push_back(g);
    end
    wait_cnt = (fpend && g != 1) ? ((wait_cnt < SL) ? wait_cnt + 1 : SL) : 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 40 && (sbq.size() != 0 || rq[0].v || rq[1].v || rq[2].v); i++) step(0);
    check("drain", sbq.size(), 0);
  endtask
  always @(negedge CLK) begin
    #2;
    if (!RESET) begin
      int nv, src;
      logic [31:0] dat;
      logic exc;
      exp_t e;
      nv = int'(fetch_resp_valid) + int'(load_resp_valid) + int'(store_resp_valid);
      check("resp_idle_zero", {!fetch_resp_valid && (fetch_resp_data != 0 || fetch_resp_exception),
                               !load_resp_valid && (load_resp_data != 0 || load_resp_exception),
                               !store_resp_valid && store_resp_exception}, 3'b000);
      if (nv > 0) begin
        src = fetch_resp_valid ? 1 : load_resp_valid ? 2 : 3;
        dat = fetch_resp_valid ? fetch_resp_data : load_resp_valid ? load_resp_data : 32'h0;
        exc = fetch_resp_exception | load_resp_exception | store_resp_exception;
        if (sbq.size() == 0) check("unexpected_resp", nv, 0);
        else begin
          e = sbq.pop_front();
          check("resp(n,src,cyc,exc,data)", {nv, src, cyc, exc, dat}, {32'd1, e.src, e.due, e.exc, e.data});
        end
      end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        check("missing_resp", nv, 1);
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 3; i++) rq[i] = '{1'b0, 32'h0, 32'h0};
    ram[32'h100] = 32'h0000_0013;
    ref_mem[32'h100] = 32'h0000_0013;
    repeat (2) @(negedge CLK);
    #1;
    check_zero("reset_outputs");
    RESET = 0;
    rq[0] = '{1'b1, 32'h100, 32'h0};
    step(0);
    drain();
    glog.delete();
    rq[2] = '{1'b1, 32'h200, 32'hDEAD_BEEF};
    rq[1] = '{1'b1, 32'h200, 32'h0};
    rq[0] = '{1'b1, 32'h104, 32'h0};
    repeat (3) step(0);
    check("order_s_l_f", {glog[0], glog[1], glog[2]}, {32'd3, 32'd2, 32'd1});
    drain();
    glog.delete();
    keep_load = 1;
    rq[0] = '{1'b1, 32'h108, 32'h0};
    repeat (6) step(0);
    keep_load = 0;
    check("starve_seq", {glog[0], glog[1], glog[2], glog[3], glog[4]}, {32'd2, 32'd2, 32'd2, 32'd2, 32'd1});
    check("starve_resume", glog[5], 2);
    drain();
    for (int i = 0; i < 3; i++) begin
      rq[1] = '{1'b1, 32'(4 * i), 32'h0};
      step(0);
    end
    drain();
    rq[1] = '{1'b1, 32'hFFFF_FFF0, 32'h0};
    step(0);
    drain();
    repeat (2000) step(1);
    drain();
    rq[1] = '{1'b1, 32'h204, 32'h0};
    step(0);
    @(posedge CLK);
    #2;
    store_req_valid = 1;
    store_req_addr = 32'h208;
    RESET = 1;
    #1;
    check_zero("reset_async");
    sbq.delete();
    wait_cnt = 0;
    @(negedge CLK);
    drive();
    RESET = 0;
    repeat (8) step(0);
    check("post_reset_quiet", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
